lzc_normalizer: RTL and testbench

Pipelined, multi-lane normaliser for the precision core. Each beat carries LANES operands of W bits. Per lane, the block counts leading zeros (unsigned mode) or redundant sign bits (signed mode), then left-shifts the operand by that count. It sits between the accumulator output and the requantisation stage, with valid/ready handshakes on both sides and a fixed two-stage pipeline.

---
 rtl/qpu_pkg.sv | 14 +
 rtl/leading_zero_counter.sv | 25 ++
 rtl/lzc_normalizer.sv | 117 +++++++++++
 tb/tb_lzc_normalizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_pkg.sv
// Shared types and helpers for the precision-core datapath blocks.
package qpu_pkg;

    typedef enum logic {
        NORM_LZ = 1'b0,
        NORM_LS = 1'b1
    } norm_mode_e;

    // Width needed to hold a leading-zero count of 0..w inclusive.
    function automatic int lzc_cw(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero counter; an all-zero input reports W.
module leading_zero_counter
    import qpu_pkg::*;
#(
    parameter int W = 32,
    localparam int CW = lzc_cw(W)
) (
    input  logic [W-1:0]  x,
    output logic [CW-1:0] count
);

    logic found;

    always_comb begin
        count = CW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                count = CW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lzc_normalizer.sv
// Two-stage multi-lane normaliser: S1 counts leading zeros / redundant sign
// bits per lane, S2 barrel-shifts each operand left by its count.
module lzc_normalizer
    import qpu_pkg::*;
#(
    parameter int W     = 32,
    parameter int LANES = 4,
    parameter int TAG_W = 4,
    localparam int CW   = lzc_cw(W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [LANES*W-1:0]    in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*W-1:0]    out_data,
    output logic [LANES*CW-1:0]   out_count,
    output logic [LANES-1:0]      out_zero,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic [LANES-1:0][W-1:0]  x;
        logic [LANES-1:0][CW-1:0] count;
        logic [LANES-1:0]         zero;
        logic [TAG_W-1:0]         tag;
    } beat_t;

    norm_mode_e               mode;
    logic [LANES-1:0][W-1:0]  lane_x;
    logic [LANES-1:0][CW-1:0] lane_cnt;
    logic [LANES-1:0]         lane_zero;
    logic [LANES-1:0][W-1:0]  shifted;

    beat_t             s1;
    beat_t             s2;
    logic [STAGES:1]   vld_pipe;
    logic              accept;
    logic              s2_load;

    assign mode   = norm_mode_e'(in_mode);
    assign lane_x = in_data;

    // Mode is fully folded into count and zero at S1, so it is not carried on.
    for (genvar i = 0; i < LANES; i++) begin : g_count
        logic          sign;
        logic [W-1:0]  lzc_in;

        assign sign = lane_x[i][W-1];
        // Sign mode: bits matching the MSB become zeros; the forced trailing 1
        // caps the run at W-1.
        assign lzc_in = (mode == NORM_LS)
                      ? {lane_x[i][W-2:0] ^ {(W-1){sign}}, 1'b1}
                      : lane_x[i];

        leading_zero_counter #(.W(W)) u_lzc (
            .x     (lzc_in),
            .count (lane_cnt[i])
        );

        assign lane_zero[i] = (mode == NORM_LS)
                            ? ((lane_x[i] == '0) || (lane_x[i] == '1))
                            : (lane_x[i] == '0);
    end

    // Log-depth barrel shifter; shifting by W or more naturally yields zero.
    for (genvar i = 0; i < LANES; i++) begin : g_shift
        logic [CW:0][W-1:0] stg;

        assign stg[0] = s1.x[i];
        for (genvar k = 0; k < CW; k++) begin : g_stg
            assign stg[k+1] = s1.count[i][k] ? (stg[k] << (2**k)) : stg[k];
        end
        assign shifted[i] = stg[CW];
    end

    // Bubble-collapsing handshake: S1 frees up whenever it drains into S2.
    assign s2_load  = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready = !vld_pipe[1] || s2_load;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (accept) begin
                s1.x     <= lane_x;
                s1.count <= lane_cnt;
                s1.zero  <= lane_zero;
                s1.tag   <= in_tag;
            end
            if (s2_load) begin
                s2.x     <= shifted;
                s2.count <= s1.count;
                s2.zero  <= s1.zero;
                s2.tag   <= s1.tag;
            end
            vld_pipe[1] <= accept  || (vld_pipe[1] && !s2_load);
            vld_pipe[2] <= s2_load || (vld_pipe[2] && !out_ready);
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_data  = s2.x;
    assign out_count = s2.count;
    assign out_zero  = s2.zero;
    assign out_tag   = s2.tag;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed bench for lzc_normalizer at W=8, LANES=2.
module tb_lzc_normalizer;

    localparam int W     = 8;
    localparam int LANES = 2;
    localparam int TAG_W = 4;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic [LANES*W-1:0]  in_data;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*W-1:0]  out_data;
    logic [LANES*CW-1:0] out_count;
    logic [LANES-1:0]    out_zero;
    logic [TAG_W-1:0]    out_tag;

    int n_total = 0;
    int n_pass  = 0;

    lzc_normalizer #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lane(input string nm, input int ln, input logic [3:0] c,
                            input logic [7:0] o, input logic z);
        check({nm, "_cnt"},  32'(out_count[ln*CW +: CW]), 32'(c));
        check({nm, "_data"}, 32'(out_data[ln*W +: W]),    32'(o));
        check({nm, "_zero"}, 32'(out_zero[ln]),           32'(z));
    endtask

    // Present one beat, then let it reach S2 with no backpressure.
    task automatic beat_through(input logic m, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [3:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = {d1, d0};
        in_tag   = t;
        step();
        in_valid = 1'b0;
        step();
    endtask

    // Independent reference: walk bits from the top one at a time.
    function automatic void ref_norm(input logic [7:0] x, input logic m,
                                     output logic [3:0] c, output logic [7:0] o,
                                     output logic z);
        int n = 0;
        if (!m) begin
            while (n < 8 && x[7-n] == 1'b0) n++;
            z = (x == 8'h00);
        end else begin
            while (n < 7 && x[6-n] == x[7]) n++;
            z = (x == 8'h00) || (x == 8'hFF);
        end
        c = 4'(n);
        o = x << n;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        step();
        step();

        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data),  0);
        check("rst_count", 32'(out_count), 0);
        check("rst_zero",  32'(out_zero),  0);
        check("rst_tag",   32'(out_tag),   0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Unsigned basics with explicit latency: presented in cycle c, valid in c+2.
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_data  = {8'h80, 8'h14};
        in_tag   = 4'd3;
        step();
        in_valid = 1'b0;
        check("lat_early", 32'(out_valid), 0);
        step();
        check("lat_valid", 32'(out_valid), 1);
        chk_lane("u_l0", 0, 4'd3, 8'hA0, 1'b0);
        chk_lane("u_l1", 1, 4'd0, 8'h80, 1'b0);
        check("u_tag", 32'(out_tag), 3);
        step();
        check("u_drained", 32'(out_valid), 0);

        beat_through(1'b0, 8'h00, 8'h01, 4'd4);
        chk_lane("lz_zero", 0, 4'd8, 8'h00, 1'b1);
        chk_lane("lz_one",  1, 4'd7, 8'h80, 1'b0);
        step();

        beat_through(1'b1, 8'hFF, 8'h00, 4'd5);
        chk_lane("ls_ones",  0, 4'd7, 8'h80, 1'b1);
        chk_lane("ls_zeros", 1, 4'd7, 8'h00, 1'b1);
        step();

        beat_through(1'b1, 8'hE5, 8'h05, 4'd6);
        chk_lane("ls_neg", 0, 4'd2, 8'h94, 1'b0);
        chk_lane("ls_pos", 1, 4'd4, 8'h50, 1'b0);
        check("ls_tag", 32'(out_tag), 6);
        step();

        // Backpressure: six tagged beats, downstream stalled for cycles 3..11.
        begin : bp
            int cyc = 0;
            int sent = 0;
            int got = 0;
            logic [15:0] snap_d = '0;
            logic [3:0]  snap_t = '0;
            in_mode = 1'b0;
            while (got < 6 && cyc < 60) begin
                out_ready = !(cyc >= 3 && cyc < 12);
                in_valid  = (sent < 6);
                in_tag    = 4'(sent);
                in_data   = {8'(8'h01 << sent), 8'(sent + 1)};
                #1;
                if (cyc == 3) begin
                    snap_d = out_data;
                    snap_t = out_tag;
                end
                if (cyc >= 4 && cyc < 12) begin
                    check("bp_hold_tag",  32'(out_tag),  32'(snap_t));
                    check("bp_hold_data", 32'(out_data), 32'(snap_d));
                end
                if (cyc == 5) begin
                    check("bp_full_ready", 32'(in_ready),  0);
                    check("bp_full_valid", 32'(out_valid), 1);
                end
                if (out_valid && out_ready) begin
                    check("bp_order", 32'(out_tag), 32'(got));
                    got++;
                end
                if (in_valid && in_ready) sent++;
                step();
                cyc++;
            end
            in_valid = 1'b0;
            check("bp_delivered", 32'(got), 6);
        end

        out_ready = 1'b1;
        step();

        // Full throughput with mode toggling every beat.
        begin : tp
            logic [7:0] e_d0 [16];
            logic [7:0] e_d1 [16];
            logic [3:0] e_c0 [16];
            logic [3:0] e_c1 [16];
            logic       e_z0 [16];
            logic       e_z1 [16];
            int idx = 0;
            int n_out = 0;
            int first = -1;
            int last = -1;
            int cyc = 0;
            logic [7:0] d0, d1;
            while (n_out < 16 && cyc < 40) begin
                in_valid = (idx < 16);
                in_mode  = idx[0];
                in_tag   = 4'(idx);
                d0 = 8'(idx * 29 + 7);
                d1 = idx[0] ? 8'(8'hFF << (idx >> 1)) : 8'(8'h80 >> (idx >> 1));
                in_data  = {d1, d0};
                #1;
                if (in_valid) begin
                    check("tp_in_ready", 32'(in_ready), 1);
                    if (in_ready) begin
                        ref_norm(d0, idx[0], e_c0[idx], e_d0[idx], e_z0[idx]);
                        ref_norm(d1, idx[0], e_c1[idx], e_d1[idx], e_z1[idx]);
                        idx++;
                    end
                end
                if (out_valid && n_out < idx) begin
                    check("tp_tag", 32'(out_tag), 32'(n_out));
                    check("tp_data", 32'(out_data), 32'({e_d1[n_out], e_d0[n_out]}));
                    check("tp_count", 32'(out_count), 32'({e_c1[n_out], e_c0[n_out]}));
                    check("tp_zero", 32'(out_zero), 32'({e_z1[n_out], e_z0[n_out]}));
                    if (first < 0) first = cyc;
                    last = cyc;
                    n_out++;
                end
                step();
                cyc++;
            end
            in_valid = 1'b0;
            check("tp_outputs", 32'(n_out), 16);
            check("tp_span", 32'(last - first), 15);
        end

        step();

        // Reset with two beats held in flight and a third beat on the input.
        begin : rs
            int seen = 0;
            out_ready = 1'b0;
            in_mode   = 1'b0;
            in_valid  = 1'b1;
            in_data   = {8'h11, 8'h22};
            in_tag    = 4'd10;
            step();
            in_tag    = 4'd11;
            step();
            check("rs_inflight", 32'(out_valid), 1);
            rst    = 1'b1;
            in_tag = 4'd12;
            step();
            rst = 1'b0;
            check("rs_valid", 32'(out_valid), 0);
            check("rs_data",  32'(out_data),  0);
            check("rs_count", 32'(out_count), 0);
            check("rs_zero",  32'(out_zero),  0);
            check("rs_tag",   32'(out_tag),   0);
            out_ready = 1'b1;
            in_data   = {8'h00, 8'h01};
            in_tag    = 4'd9;
            #1;
            check("rs_fresh_ready", 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid) begin
                    check("rs_fresh_tag", 32'(out_tag), 9);
                    chk_lane("rs_fresh_l0", 0, 4'd7, 8'h80, 1'b0);
                    chk_lane("rs_fresh_l1", 1, 4'd8, 8'h00, 1'b1);
                    seen++;
                end
                step();
            end
            check("rs_fresh_once", 32'(seen), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
